// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          PC_W              = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD          = 32'h6800_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Next-PC priority select plus out-of-range / misalignment fault detection.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int                N        = 7,
    parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                 i_rst,
    input  fetch_state_t         i_state,
    input  logic                 i_start,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [PC_W-1:0]      i_branch_target,
    input  logic [PC_W-1:0]      i_pc,
    input  logic                 i_halt_hit,
    output logic [PC_W-1:0]      o_next_pc,
    output logic                 o_fault_next
);

    logic w_forced;
    logic w_out_of_range;
    logic w_misaligned;

    always_comb begin
        o_next_pc = i_pc;
        w_forced  = 1'b1;
        if (i_rst) begin
            o_next_pc = RESET_PC;
        end else begin
            case (i_state)
                IDLE: o_next_pc = RESET_PC;
                HALT: o_next_pc = i_start ? RESET_PC : i_pc;
                RUN: begin
                    if (i_branch_taken) begin
                        o_next_pc = {i_branch_target[PC_W-1:2], 2'b00};
                    end else if (i_stall || i_halt_hit) begin
                        o_next_pc = i_pc;
                    end else begin
                        o_next_pc = i_pc + 32'd4;
                        w_forced  = 1'b0;
                    end
                end
                default: o_next_pc = RESET_PC;
            endcase
        end
    end

    // Only the sequential increment can carry a misalignment through; forced values are already aligned.
    assign w_out_of_range = |o_next_pc[PC_W-1:N+2];
    assign w_misaligned   = !w_forced && (o_next_pc[1:0] != 2'b00);
    assign o_fault_next   = !i_rst && (i_state == RUN) && (w_out_of_range || w_misaligned);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction memory one cycle ahead.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                N         = 7,
    parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]       HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_target,
    output logic [N-1:0]         im_addr,
    input  logic [31:0]          im_douta,
    output logic [31:0]          of_instr,
    output logic [PC_W-1:0]      of_pc,
    output logic                 of_valid,
    output logic                 halted,
    output logic                 fetch_fault,
    output logic [31:0]          fetch_count
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic            r_valid;
    logic            w_valid_next;
    logic            r_fault;
    logic            w_fault_next;
    logic [31:0]     r_count;
    logic            w_accept;
    logic            w_halt_hit;

    assign w_accept   = (r_state == RUN) && r_valid && !stall && !branch_taken;
    assign w_halt_hit = w_accept && (im_douta == HALT_WORD);

    pc_next_mux #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc_next_mux (
        .i_rst           (rst),
        .i_state         (r_state),
        .i_start         (start),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_pc            (r_pc),
        .i_halt_hit      (w_halt_hit),
        .o_next_pc       (w_next_pc),
        .o_fault_next    (w_fault_next)
    );

    // Memory is addressed with next_pc so its registered output pairs with r_pc.
    assign im_addr = w_next_pc[N+1:2];

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_next_pc;
            r_valid <= w_valid_next;
            if (w_fault_next) begin
                r_fault <= 1'b1;
            end
            if (w_accept && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                w_valid_next = 1'b0;
                if (start) begin
                    w_state_next = RUN;
                    w_valid_next = 1'b1;
                end
            end
            RUN: begin
                if (w_halt_hit || w_fault_next) begin
                    w_state_next = HALT;
                    w_valid_next = 1'b0;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            HALT: begin
                w_valid_next = 1'b0;
                if (start) begin
                    w_state_next = RUN;
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    assign of_instr    = im_douta;
    assign of_pc       = r_pc;
    assign of_valid    = r_valid;
    assign halted      = (r_state == HALT);
    assign fetch_fault = r_fault;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plan plus randomized traffic against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam int          N    = 7;
    localparam int          MEMW = 1 << N;
    localparam logic [31:0] HW   = 32'hFFFF_FFFF;
    localparam logic [31:0] VA   = 32'h1111_0001;
    localparam logic [31:0] VB   = 32'h2222_0002;
    localparam logic [31:0] VC   = 32'h3333_0003;
    localparam logic [31:0] VD   = 32'h4444_0004;

    logic        clka = 1'b0;
    logic        rst, start, stall, branch_taken;
    logic [31:0] branch_target;
    logic [N-1:0] im_addr;
    logic [31:0] im_douta;
    logic [31:0] of_instr, of_pc, fetch_count;
    logic        of_valid, halted, fetch_fault;

    logic [31:0] mem [0:MEMW-1];

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: plain flags and byte-address arithmetic.
    bit          m_run, m_halt, m_valid, m_fault, m_fault_halt;
    logic [31:0] m_pc, m_count;

    fetch_unit #(.N(N), .RESET_PC(32'h0), .HALT_WORD(HW)) dut (
        .clka          (clka),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .im_addr       (im_addr),
        .im_douta      (im_douta),
        .of_instr      (of_instr),
        .of_pc         (of_pc),
        .of_valid      (of_valid),
        .halted        (halted),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    always #5 clka = ~clka;
    always @(posedge clka) im_douta <= mem[im_addr];

    function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
        return mem[(byte_addr % (4 * MEMW)) / 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit s, input bit st, input bit b, input logic [31:0] t);
        logic [31:0] np;
        bit          hit_halt;
        if (r) begin
            m_run = 0; m_halt = 0; m_valid = 0; m_fault = 0; m_fault_halt = 0;
            m_pc = 32'h0; m_count = 32'h0;
        end else if (!m_run && !m_halt) begin
            m_pc = 32'h0;
            if (s) begin m_run = 1; m_valid = 1; end
        end else if (m_halt) begin
            if (s) begin
                m_halt = 0; m_run = 1; m_valid = 1; m_fault_halt = 0; m_pc = 32'h0;
            end
        end else begin
            hit_halt = 0;
            if (m_valid && !st && !b) begin
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                hit_halt = (word_at(m_pc) == HW);
            end
            if (b)             np = t - (t % 4);
            else if (st)       np = m_pc;
            else if (hit_halt) np = m_pc;
            else               np = m_pc + 4;
            m_pc = np;
            if (hit_halt) begin
                m_run = 0; m_halt = 1; m_valid = 0;
            end else if (np >= 4 * MEMW) begin
                m_run = 0; m_halt = 1; m_valid = 0; m_fault = 1; m_fault_halt = 1;
            end else begin
                m_valid = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("of_valid", {31'd0, of_valid}, {31'd0, m_valid});
        check("halted", {31'd0, halted}, {31'd0, m_halt});
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        check("fetch_count", fetch_count, m_count);
        if (m_valid) begin
            check("of_pc", of_pc, m_pc);
            check("of_instr", of_instr, word_at(m_pc));
        end else if (m_halt && !m_fault_halt) begin
            check("held_pc", of_pc, m_pc);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit st, input bit b, input logic [31:0] t);
        rst = r; start = s; stall = st; branch_taken = b; branch_target = t;
        model_update(r, s, st, b, t);
        @(posedge clka);
        #1;
        compare_all();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 32'h0); endtask

    initial begin
        logic [31:0] v;
        rst = 1; start = 0; stall = 0; branch_taken = 0; branch_target = 0;
        for (int i = 0; i < MEMW; i++) begin
            v = $urandom;
            mem[i] = (v == HW) ? 32'h0 : v;
        end
        mem[0] = VA; mem[1] = VB; mem[2] = VC; mem[3] = VD; mem[5] = HW;

        // Reset, idle, start, sequential fetch, halt word
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("rst_count", fetch_count, 32'd0);
        repeat (3) begin
            idle();
            check("idle_valid", {31'd0, of_valid}, 32'd0);
        end
        step(0, 1, 0, 0, 32'h0);
        check("seq_pc0", of_pc, 32'h0);  check("seq_i0", of_instr, VA);
        idle(); check("seq_pc4", of_pc, 32'h4);  check("seq_i1", of_instr, VB);
        idle(); check("seq_pc8", of_pc, 32'h8);  check("seq_i2", of_instr, VC);
        idle(); check("seq_pc12", of_pc, 32'hC); check("seq_i3", of_instr, VD);
        idle(); check("seq_count4", fetch_count, 32'd4);
        idle(); check("halt_word_pc", of_pc, 32'd20); check("halt_word", of_instr, HW);
        idle(); check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, of_valid}, 32'd0);
        check("halt_pc", of_pc, 32'd20); check("halt_count", fetch_count, 32'd6);
        idle(); check("halt_pc_held", of_pc, 32'd20);

        // Restart from HALT, then stall at pc 8
        step(0, 1, 0, 0, 32'h0);
        check("restart_pc", of_pc, 32'h0); check("restart_valid", {31'd0, of_valid}, 32'd1);
        idle(); idle();
        repeat (3) begin
            step(0, 0, 1, 0, 32'h0);
            check("stall_pc", of_pc, 32'h8); check("stall_instr", of_instr, VC);
            check("stall_count", fetch_count, 32'd8);
        end
        idle(); check("stall_release", of_pc, 32'hC);

        // Branch redirect, alone and with simultaneous stall
        step(1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        idle();
        step(0, 0, 0, 1, 32'h0000_0043);
        check("br_pc", of_pc, 32'h40); check("br_instr", of_instr, mem[16]);
        idle();
        step(0, 0, 1, 1, 32'h0000_0043);
        check("br_stall_pc", of_pc, 32'h40);

        // Out-of-range branch faults; fault survives start, clears on rst
        step(0, 0, 0, 1, 32'h0000_0200);
        check("fault_flag", {31'd0, fetch_fault}, 32'd1);
        check("fault_halted", {31'd0, halted}, 32'd1);
        check("fault_valid", {31'd0, of_valid}, 32'd0);
        step(0, 1, 0, 0, 32'h0);
        check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        check("fault_restart_halted", {31'd0, halted}, 32'd0);
        idle();
        step(1, 1, 0, 0, 32'h0);
        check("fault_cleared", {31'd0, fetch_fault}, 32'd0);

        // Reset mid-run at pc 12
        step(0, 1, 0, 0, 32'h0);
        idle(); idle(); idle();
        check("mid_pc12", of_pc, 32'hC);
        step(1, 0, 0, 0, 32'h0);
        check("mid_rst_valid", {31'd0, of_valid}, 32'd0);
        check("mid_rst_pc", of_pc, 32'h0);
        check("mid_rst_count", fetch_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < MEMW; i++) begin
            v = $urandom;
            if (v == HW) v = 32'h0;
            mem[i] = ($urandom_range(0, 15) == 0) ? HW : v;
        end
        step(1, 0, 0, 0, 32'h0);
        for (int c = 0; c < 600; c++) begin
            bit r, s, st, b;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 12);
            t  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 32'h3FF)
                                             : $urandom_range(0, 4 * MEMW - 1);
            step(r, s, st, b, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
